// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the HI/LO multiply/divide sequencer.
//               Provides the operand width default, the operation encodings
//               carried on i_op, and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Default operand / HI / LO width
    localparam int MULDIV_WIDTH = 32;

    // i_op encodings; bit 1 selects divide, bit 0 selects signed
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_RUN  = 2'b10,
        ST_FIX  = 2'b11
    } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the mul/div loop.
//               Multiply: 2*WIDTH shift-add; the high half gains the
//               multiplicand when the current multiplier LSB is set, then the
//               whole accumulator shifts right by one.
//               Divide: restoring step; the remainder (high half) takes the
//               next dividend bit from the low half, a trial subtract decides
//               the quotient bit, and the low half shifts left.
// Ports       : i_acc   - accumulator (mul) / {remainder, dividend-quotient}
//               i_opnd  - multiplicand (mul) / divisor (div)
//               i_div   - 1 selects divide mode
//               o_acc   - next accumulator; in divide mode bit 0 is left clear
//               o_qbit  - quotient bit produced this iteration (0 for mul)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_qbit
);

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_hi    = i_acc[2*WIDTH-1:WIDTH];
    assign w_lo    = i_acc[WIDTH-1:0];

    // Carry bit of the add becomes the new MSB after the right shift
    assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});

    // Trial remainder is WIDTH+1 bits wide; when it is >= divisor the true
    // difference is below the divisor, so a WIDTH-bit subtract is exact.
    assign w_shift = {w_hi, w_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_opnd});
    assign w_diff  = w_shift[WIDTH-1:0] - i_opnd;

    always_comb begin
        o_acc  = '0;
        o_qbit = 1'b0;
        if (i_div) begin
            o_acc  = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), w_lo[WIDTH-2:0], 1'b0};
            o_qbit = w_ge;
        end else begin
            o_acc  = {w_sum, w_lo[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative multiply/divide unit owning the HI/LO pair.
//               IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> IDLE,
//               latency WIDTH+3 from the issue cycle to o_done.
//               MTHI/MTLO write HI/LO directly while idle.
// Config      : MULDIV_SIGNED_EN - when defined, MULT/DIV take absolute
//               values in PREP and fix result signs in FIX. When undefined,
//               MULT/DIV behave as MULTU/DIVU.
// Ports       : i_clk, i_rst (sync, active high)
//               i_start, i_op, i_srcA, i_srcB - operation issue
//               i_mt_hi, i_mt_lo              - HI/LO direct writes
//               o_busy, o_done, o_div_by_zero - status
//               o_hi, o_lo                    - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_srcA,
    input  logic [WIDTH-1:0] i_srcB,
    input  logic             i_mt_hi,
    input  logic             i_mt_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_step_acc;
    logic               w_qbit;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    always_comb begin
        w_is_div = 1'b0;
        case (r_op)
            OP_DIVU, OP_DIV: w_is_div = 1'b1;
            default:         w_is_div = 1'b0;
        endcase
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_div  (w_is_div),
        .o_acc  (w_step_acc),
        .o_qbit (w_qbit)
    );

`ifdef MULDIV_SIGNED_EN
    logic w_signed;
    logic r_neg_res;
    logic r_neg_rem;

    assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    // Two's-complement negate of the most negative value yields itself,
    // which is also its correct unsigned magnitude.
    assign w_a_abs  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_b_abs  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (r_state == ST_PREP) begin
            r_neg_res <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            r_neg_rem <= w_signed && r_a[WIDTH-1];
        end
    end

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`else
    assign w_a_abs = r_a;
    assign w_b_abs = r_b;
    assign w_prod  = r_acc;
    assign w_quo   = r_acc[WIDTH-1:0];
    assign w_rem   = r_acc[2*WIDTH-1:WIDTH];
`endif

    // Divide by zero bypasses sign correction: HI returns the raw dividend
    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (w_is_div) begin
            if (r_dbz) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_PREP;
            ST_PREP: w_next = ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath and HI/LO
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_opnd <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op  <= i_op;
                        r_a   <= i_srcA;
                        r_b   <= i_srcB;
                        r_dbz <= 1'b0;
                    end else begin
                        if (i_mt_hi) r_hi <= i_srcA;
                        if (i_mt_lo) r_lo <= i_srcA;
                    end
                end
                ST_PREP: begin
                    r_cnt <= CNT_W'(WIDTH - 1);
                    r_dbz <= w_is_div && (r_b == '0);
                    if (w_is_div) begin
                        r_acc  <= {{WIDTH{1'b0}}, w_a_abs};
                        r_opnd <= w_b_abs;
                    end else begin
                        r_acc  <= {{WIDTH{1'b0}}, w_b_abs};
                        r_opnd <= w_a_abs;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_step_acc | {{(2*WIDTH-1){1'b0}}, w_qbit};
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_FIX: begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule : muldiv_sequencer
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer.
//               Expected results for signed ops follow MULDIV_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         r_clk = 1'b0;
    logic         r_rst;
    logic         r_start;
    logic [1:0]   r_op;
    logic [W-1:0] r_srcA;
    logic [W-1:0] r_srcB;
    logic         r_mt_hi;
    logic         r_mt_lo;
    logic         w_busy;
    logic         w_done;
    logic         w_dbz;
    logic [W-1:0] w_hi;
    logic [W-1:0] w_lo;

    int total = 0;
    int bad   = 0;

    always #5 r_clk = ~r_clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .i_clk         (r_clk),
        .i_rst         (r_rst),
        .i_start       (r_start),
        .i_op          (r_op),
        .i_srcA        (r_srcA),
        .i_srcB        (r_srcB),
        .i_mt_hi       (r_mt_hi),
        .i_mt_lo       (r_mt_lo),
        .o_busy        (w_busy),
        .o_done        (w_done),
        .o_div_by_zero (w_dbz),
        .o_hi          (w_hi),
        .o_lo          (w_lo)
    );

    // Called at a falling edge; start is sampled on the following rising edge
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        r_op    = op;
        r_srcA  = a;
        r_srcB  = b;
        r_start = 1'b1;
        @(negedge r_clk);
        r_start = 1'b0;
    endtask

    // Returns cycles from issue to o_done (bounded) and busy cycles seen
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 1;
        nbusy = 0;
        while (!w_done && lat < 100) begin
            if (w_busy) nbusy++;
            @(negedge r_clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        r_rst = 1'b1; r_start = 1'b0; r_op = 2'b00; r_srcA = '0; r_srcB = '0;
        r_mt_hi = 1'b0; r_mt_lo = 1'b0;
        repeat (3) @(negedge r_clk);
        r_rst = 1'b0;
        total++;
        if ({w_busy, w_done, w_dbz} !== 3'b000 || w_hi !== '0 || w_lo !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h required all 0",
                     w_busy, w_done, w_dbz, w_hi, w_lo);
        end
    endtask

    task automatic test_multu();
        int lat, nb;
        total++;
        if (w_busy !== 1'b0) begin
            bad++; $display("FAIL multu_busy_issue: got %b required 0", w_busy);
        end
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, nb);
        total++;
        if (lat != 35) begin bad++; $display("FAIL multu_latency: got %0d required 35", lat); end
        total++;
        if (nb != 34) begin bad++; $display("FAIL multu_busy_cycles: got %0d required 34", nb); end
        total++;
        if (w_busy !== 1'b0) begin bad++; $display("FAIL multu_busy_done: got %b required 0", w_busy); end
        total++;
        if (w_hi !== 32'hFFFF_FFFE || w_lo !== 32'h0000_0001) begin
            bad++; $display("FAIL multu_result: hi=%h lo=%h required fffffffe 00000001", w_hi, w_lo);
        end
        @(negedge r_clk);
        total++;
        if (w_done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse: got %b required 0", w_done); end
    endtask

    task automatic test_mult();
        int lat, nb;
        logic [W-1:0] eh;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, nb);
`ifdef MULDIV_SIGNED_EN
        eh = 32'hFFFF_FFFF;
`else
        eh = 32'h0000_0006;
`endif
        total++;
        if (lat != 35 || w_hi !== eh || w_lo !== 32'hFFFF_FFEB) begin
            bad++; $display("FAIL mult_neg3x7: lat=%0d hi=%h lo=%h required 35 %h ffffffeb", lat, w_hi, w_lo, eh);
        end
    endtask

    task automatic test_div();
        int lat, nb;
        logic [W-1:0] eh, el;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, nb);
`ifdef MULDIV_SIGNED_EN
        eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD;
`else
        eh = 32'h0000_0001; el = 32'h7FFF_FFFC;
`endif
        total++;
        if (lat != 35 || w_hi !== eh || w_lo !== el) begin
            bad++; $display("FAIL div_neg7by2: lat=%0d hi=%h lo=%h required 35 %h %h", lat, w_hi, w_lo, eh, el);
        end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, nb);
`ifdef MULDIV_SIGNED_EN
        eh = 32'h0000_0000; el = 32'h8000_0000;
`else
        eh = 32'h8000_0000; el = 32'h0000_0000;
`endif
        total++;
        if (w_hi !== eh || w_lo !== el || w_dbz !== 1'b0) begin
            bad++; $display("FAIL div_overflow: hi=%h lo=%h dbz=%b required %h %h 0", w_hi, w_lo, w_dbz, eh, el);
        end
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, nb);
        total++;
        if (w_hi !== 32'd2 || w_lo !== 32'd14) begin
            bad++; $display("FAIL divu_100by7: hi=%h lo=%h required 2 14", w_hi, w_lo);
        end
    endtask

    task automatic test_div_by_zero();
        int lat, nb;
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(lat, nb);
        total++;
        if (lat != 35 || w_hi !== 32'h64 || w_lo !== 32'hFFFF_FFFF || w_dbz !== 1'b1) begin
            bad++; $display("FAIL divu_by_zero: lat=%0d hi=%h lo=%h dbz=%b required 35 64 ffffffff 1",
                            lat, w_hi, w_lo, w_dbz);
        end
        repeat (3) @(negedge r_clk);
        total++;
        if (w_dbz !== 1'b1) begin bad++; $display("FAIL dbz_sticky: got %b required 1", w_dbz); end
        issue(OP_MULTU, 32'd2, 32'd3);
        total++;
        if (w_dbz !== 1'b0) begin bad++; $display("FAIL dbz_clear_on_start: got %b required 0", w_dbz); end
        wait_done(lat, nb);
        total++;
        if (w_hi !== 32'd0 || w_lo !== 32'd6 || w_dbz !== 1'b0) begin
            bad++; $display("FAIL multu_2x3: hi=%h lo=%h dbz=%b required 0 6 0", w_hi, w_lo, w_dbz);
        end
    endtask

    task automatic test_mt();
        int lat, nb;
        r_srcA = 32'h0000_1234; r_mt_hi = 1'b1;
        @(negedge r_clk);
        r_mt_hi = 1'b0;
        total++;
        if (w_hi !== 32'h0000_1234 || w_lo !== 32'd6) begin
            bad++; $display("FAIL mthi: hi=%h lo=%h required 00001234 00000006", w_hi, w_lo);
        end
        r_srcA = 32'h0000_5678; r_mt_lo = 1'b1;
        @(negedge r_clk);
        r_mt_lo = 1'b0;
        total++;
        if (w_hi !== 32'h0000_1234 || w_lo !== 32'h0000_5678) begin
            bad++; $display("FAIL mtlo: hi=%h lo=%h required 00001234 00005678", w_hi, w_lo);
        end
        // Start together with both strobes: start wins
        r_mt_hi = 1'b1; r_mt_lo = 1'b1;
        issue(OP_MULTU, 32'd6, 32'd7);
        r_mt_hi = 1'b0; r_mt_lo = 1'b0;
        total++;
        if (w_hi !== 32'h0000_1234 || w_lo !== 32'h0000_5678 || w_busy !== 1'b1) begin
            bad++; $display("FAIL start_beats_mt: hi=%h lo=%h busy=%b required 00001234 00005678 1",
                            w_hi, w_lo, w_busy);
        end
        wait_done(lat, nb);
        total++;
        if (w_hi !== 32'd0 || w_lo !== 32'd42) begin
            bad++; $display("FAIL start_beats_mt_result: hi=%h lo=%h required 0 42", w_hi, w_lo);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, nb;
        issue(OP_MULTU, 32'd3, 32'd5);
        repeat (4) @(negedge r_clk);
        r_srcA = 32'hDEAD_BEEF; r_srcB = 32'd1; r_op = OP_DIVU;
        r_mt_hi = 1'b1; r_mt_lo = 1'b1; r_start = 1'b1;
        @(negedge r_clk);
        r_mt_hi = 1'b0; r_mt_lo = 1'b0; r_start = 1'b0;
        total++;
        if (w_hi !== 32'd0 || w_lo !== 32'd42 || w_busy !== 1'b1) begin
            bad++; $display("FAIL busy_ignore_mt: hi=%h lo=%h busy=%b required 0 42 1", w_hi, w_lo, w_busy);
        end
        wait_done(lat, nb);
        total++;
        if (lat != 30 || w_hi !== 32'd0 || w_lo !== 32'd15) begin
            bad++; $display("FAIL busy_ignore_result: lat=%0d hi=%h lo=%h required 30 0 15", lat, w_hi, w_lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        issue(OP_MULTU, 32'd1000, 32'd1000);
        wait_done(lat, nb);
        issue(OP_DIVU, 32'd1000, 32'd10);
        wait_done(lat, nb);
        total++;
        if (lat != 35 || w_hi !== 32'd0 || w_lo !== 32'd100) begin
            bad++; $display("FAIL back_to_back: lat=%0d hi=%h lo=%h required 35 0 100", lat, w_hi, w_lo);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, nb;
        int ndone;
        issue(OP_MULTU, 32'h1234_5678, 32'd9);
        repeat (11) @(negedge r_clk);
        r_rst = 1'b1;
        @(negedge r_clk);
        r_rst = 1'b0;
        total++;
        if (w_busy !== 1'b0 || w_done !== 1'b0 || w_hi !== '0 || w_lo !== '0) begin
            bad++; $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
                            w_busy, w_done, w_hi, w_lo);
        end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (w_done || w_busy) ndone++;
            @(negedge r_clk);
        end
        total++;
        if (ndone != 0) begin bad++; $display("FAIL reset_no_done: got %0d active cycles required 0", ndone); end
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_done(lat, nb);
        total++;
        if (lat != 35 || w_hi !== 32'd0 || w_lo !== 32'd42) begin
            bad++; $display("FAIL after_reset_6x7: lat=%0d hi=%h lo=%h required 35 0 42", lat, w_hi, w_lo);
        end
    endtask

    initial begin
        r_rst = 1'b1; r_start = 1'b0; r_op = 2'b00; r_srcA = '0; r_srcB = '0;
        r_mt_hi = 1'b0; r_mt_lo = 1'b0;
        @(negedge r_clk);
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_mt();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_muldiv_sequencer
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It sits beside the EX-stage ALU, accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from the decoded control stream, and runs a shift-add / restoring-divide loop for WIDTH cycles. While an operation is in flight it raises a busy flag that the hazard unit uses to stall MFHI/MFLO and any further mul/div issue.

## Interface
- WIDTH, 32, operand and HI/LO width; loop runs WIDTH iterations
- i_clk  in  1  core clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  issue pulse from EX stage; sampled only in IDLE
- i_op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- i_srcA  in  WIDTH  multiplicand / dividend; also MTHI/MTLO data
- i_srcB  in  WIDTH  multiplier / divisor
- i_mt_hi  in  1  MTHI write strobe
- i_mt_lo  in  1  MTLO write strobe
- o_busy  out  1  high while state != IDLE (registered-state decode)
- o_done  out  1  one-cycle pulse when HI/LO updated by an operation
- o_div_by_zero  out  1  sticky until next i_start; set when a divide had i_srcB == 0
- o_hi  out  WIDTH  HI register
- o_lo  out  WIDTH  LO register

## Operation
- FSM states: IDLE, PREP, RUN, FIX. Reset -> IDLE; all outputs 0.
- IDLE: i_start=1 -> latch op/operands, clear o_div_by_zero, go PREP. Else MTHI/MTLO write o_hi/o_lo from i_srcA (both strobes may fire together).
- i_start and i_mt_* in the same cycle: start wins, MT ignored.
- i_start or i_mt_* while busy: ignored, no state change.
- PREP: signed ops take absolute values of operands, record result sign(s); unsigned ops pass through. Iteration counter loaded with WIDTH-1. Divisor zero detected here.
- RUN: one iteration per cycle. Multiply: 2*WIDTH-bit shift-add accumulator. Divide: restoring division, remainder WIDTH+1 bits for the trial subtract. Counter decrements; at 0 -> FIX.
- FIX: signed multiply negates 2*WIDTH product if signs differed. Signed divide: quotient negated if signs differed, remainder takes dividend's sign. Write HI (product high / remainder), LO (product low / quotient) -> IDLE.
- Divide by zero: LO = all ones, HI = original i_srcA, no sign correction, o_div_by_zero=1; full latency still taken.
- Overflow -2^(WIDTH-1) / -1: LO = 0x80000000, HI = 0 (natural wrap, no flag).
- Reset mid-operation: IDLE next cycle, HI/LO cleared, no o_done.

## Timing
- Start sampled in cycle 0. Cycle 1 PREP, cycles 2..WIDTH+1 RUN, cycle WIDTH+2 FIX, cycle WIDTH+3 IDLE with o_done=1 and new o_hi/o_lo visible. Latency WIDTH+3 (35 for WIDTH=32).
- o_busy high cycles 1..WIDTH+2; low in issue cycle 0 and in the o_done cycle.
- Back-to-back: a new i_start is accepted in the o_done cycle.
- MTHI/MTLO: o_hi/o_lo update one cycle after the strobe.

## Configuration
- MULDIV_SIGNED_EN defined: MULT/DIV perform sign handling in PREP/FIX as above.
- Undefined: op bit 0 is ignored, MULT/DIV behave as MULTU/DIVU; sign logic and negators are absent. FSM still passes through PREP and FIX, so latency is unchanged.

## Structure
- Package muldiv_pkg holds the i_op encodings (OP_MULTU/MULT/DIVU/DIV), FSM state encodings, and the WIDTH default.
- One sub-module, muldiv_step: combinational single iteration. Inputs are accumulator/remainder, operand, and mode. Output is the next accumulator/remainder and quotient bit.
- Controller FSM, counter, sign flags and HI/LO registers live in the top.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, o_done exactly 35 cycles after start, o_busy high 34 cycles.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Without MULDIV_SIGNED_EN, the same operands give HI=0x00000006, LO=0xFFFFFFEB.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064, o_div_by_zero=1. The flag clears on the next start.
- MTHI 0x1234 in IDLE -> o_hi=0x1234 next cycle. MTLO and i_start asserted while busy -> no effect on HI/LO or FSM.
- i_rst asserted at RUN cycle 10 -> o_busy=0 and o_hi=o_lo=0 next cycle, no o_done. A following MULTU 6x7 -> LO=42, HI=0.
